// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and FSM state type for the serial arithmetic blocks.
package arith_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_sub_slice.sv
// One combinational subtract slice: d = x - y - borrowIn with borrow out.
module sub_slice #(
  parameter int unsigned SLICE = arith_pkg::SLICE
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             borrowIn,
  output logic [SLICE-1:0] d,
  output logic             borrowOutSlice
);

  logic [SLICE:0] sum;

  // Subtraction as x + ~y + ~borrow; the carry out is the inverted borrow.
  always_comb begin
    sum            = {1'b0, x} + {1'b0, ~y} + {{SLICE{1'b0}}, ~borrowIn};
    d              = sum[SLICE-1:0];
    borrowOutSlice = ~sum[SLICE];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: one SLICE-bit slice of a - b - bIn per clock, LSB slice first.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = arith_pkg::WIDTH,
  parameter int unsigned SLICE = arith_pkg::SLICE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     bIn,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         diff,
  output logic [WIDTH/SLICE-1:0]   borrowOut
);

  import arith_pkg::*;

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                borrow_q, borrow_d;
  logic [WIDTH-1:0]    diff_q, diff_d;
  logic [NSLICE-1:0]   bout_q, bout_d;
  logic                done_q, done_d;

  logic [SLICE-1:0]    slice_x, slice_y, slice_d;
  logic                slice_bo;

  always_comb begin
    slice_x = a_q[idx_q*SLICE +: SLICE];
    slice_y = b_q[idx_q*SLICE +: SLICE];
  end

  sub_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .x             (slice_x),
    .y             (slice_y),
    .borrowIn      (borrow_q),
    .d             (slice_d),
    .borrowOutSlice(slice_bo)
  );

  // borrow_q carries bIn into slice 0, then each slice's borrow into the next.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bIn;
          diff_d   = '0;
          bout_d   = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[idx_q*SLICE +: SLICE] = slice_d;
        bout_d[idx_q]                = slice_bo;
        borrow_d                     = slice_bo;
        if (idx_q == IDXW'(NSLICE - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign diff      = diff_q;
  assign borrowOut = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: stimulus pushes expectations, monitor checks on done.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        bIn;
  logic        busy, done;
  logic [15:0] diff;
  logic [3:0]  borrowOut;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  bo;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  bit   b2b_mode = 1'b0;
  bit   prev_done = 1'b0;

  nibble_serial_subtractor #(
    .WIDTH(16),
    .SLICE(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bIn      (bIn),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrowOut(borrowOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high in consecutive cycles, required single-cycle pulse");
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: diff=%h borrowOut=%b, required no result pending", diff, borrowOut);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (diff !== e.d) begin
          errors++;
          $display("FAIL diff: got %h required %h", diff, e.d);
        end
        checks++;
        if (borrowOut !== e.bo) begin
          errors++;
          $display("FAIL borrowOut: got %b required %b", borrowOut, e.bo);
        end
      end
      if (b2b_mode && last_done_cyc >= 0) begin
        checks++;
        if (cyc - last_done_cyc != 6) begin
          errors++;
          $display("FAIL issue_interval: got %0d edges required 6", cyc - last_done_cyc);
        end
      end
      last_done_cyc = cyc;
    end
    prev_done = done;
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        input logic [15:0] ed, input logic [3:0] eb, input bit disturb);
    int done_at;
    int busy_cnt;
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_v; bIn = tbin; start = 1'b1;
    @(posedge clk);
    e.d = ed; e.bo = eb;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    done_at = -1;
    busy_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = n;
      if (disturb) begin
        start = (n < 3);
        a = 16'($urandom);
        b = 16'($urandom);
        bIn = 1'($urandom);
      end
      if (!busy) break;
    end
    checks++;
    if (done_at != 4) begin
      errors++;
      $display("FAIL done_latency: done seen at cycle %0d after accept, required 4", done_at);
    end
    checks++;
    if (busy_cnt != 5) begin
      errors++;
      $display("FAIL busy_cycles: got %0d required 5", busy_cnt);
    end
    checks++;
    if (diff !== ed || borrowOut !== eb) begin
      errors++;
      $display("FAIL hold_after_done: diff=%h borrowOut=%b required %h %b", diff, borrowOut, ed, eb);
    end
  endtask

  initial begin
    int accepts;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bIn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || borrowOut !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h borrowOut=%b required all 0", busy, done, diff, borrowOut);
    end
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 4'b0000, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1111, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0111, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 4'b1111, 1'b0);
    run_op(16'hABCD, 16'h1234, 1'b1, 16'h9998, 4'b0000, 1'b0);
    run_op(16'h0100, 16'h00FF, 1'b0, 16'h0001, 4'b0011, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h00FE, 4'b0000, 1'b1);

    // Asynchronous reset between edges T+2 and T+3.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; bIn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || borrowOut !== 4'h0) begin
      errors++;
      $display("FAIL mid_op_reset: busy=%b done=%b diff=%h borrowOut=%b required all 0", busy, done, diff, borrowOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 4'b0001, 1'b0);

    // Back-to-back with start held high.
    b2b_mode = 1'b1;
    last_done_cyc = -1;
    accepts = 0;
    @(negedge clk);
    a = 16'h0003; b = 16'h0001; bIn = 1'b0; start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (!busy) begin
        if (accepts == 3) begin
          start = 1'b0;
          break;
        end
        q.push_back('{d: 16'h0002, bo: 4'b0000});
        accepts++;
      end
    end
    repeat (8) @(negedge clk);
    b2b_mode = 1'b0;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d expected results never delivered, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
